tpu_mm_sequencer: RTL and testbench



---
 rtl/tpu_mm_sequencer_pkg.sv | 27 ++
 rtl/tpu_mm_sequencer_if.sv | 13 +
 rtl/tpu_mm_sequencer.sv | 178 +++++++++++++++++
 tb/tb_tpu_mm_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_mm_sequencer_pkg.sv
// tpu_seq_pkg: sequencer FSM state encoding and the TPU bus memory map.
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_AB = 3'd1,
    ST_CLR_C   = 3'd2,
    ST_TRIG    = 3'd3,
    ST_WAIT    = 3'd4,
    ST_READ_C  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // TPU memory map; PARK_ADDR decodes to nothing inside the array.
  localparam logic [15:0] A_BASE     = 16'h0100;
  localparam logic [15:0] B_BASE     = 16'h0200;
  localparam logic [15:0] C_BASE     = 16'h0300;
  localparam logic [15:0] MM_TRIG    = 16'h0400;
  localparam logic [15:0] PARK_ADDR  = 16'h0000;
  localparam logic [15:0] ROW_STRIDE = 16'd8;

  // Bus address of row idx of a matrix region.
  function automatic logic [15:0] row_addr(input logic [15:0] base, input logic [5:0] idx);
    return base + ROW_STRIDE * {10'd0, idx};
  endfunction

endpackage

// File: rtl/tpu_mm_sequencer_if.sv
// TPU memory-mapped bus: master = sequencer, slave = TPU array port.
interface tpu_mm_sequencer_if #(
  parameter int DATAW = 64,
  parameter int ADDRW = 16
);
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  modport master (output tpu_r_w, tpu_addr, tpu_wdata, input tpu_rdata);
  modport slave  (input tpu_r_w, tpu_addr, tpu_wdata, output tpu_rdata);
endinterface

// File: rtl/tpu_mm_sequencer.sv
// tpu_mm_sequencer: runs one full matrix multiply on the TPU over its bus.
// Load A/B rows from source RAM, clear C, trigger, wait, copy C half-rows out.
// Optional build macro TPU_SEQ_ACCUM_EN: accum sampled with start skips the C clear.
module tpu_mm_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int DATAW      = 64,
  parameter int ADDRW      = 16,
  parameter int DIM        = 8,
  parameter int SRC_AW     = 10,
  parameter int RUN_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [SRC_AW-1:0] dst_base,
  input  logic              accum,
  output logic              busy,
  output logic              done,
  output logic              src_rd,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [DATAW-1:0]  src_rdata,
  output logic              dst_we,
  output logic [SRC_AW-1:0] dst_addr,
  output logic [DATAW-1:0]  dst_wdata,
  tpu_mm_sequencer_if.master tpu
);

  localparam logic [5:0] ROWS_A    = 6'(DIM);
  localparam logic [5:0] LAST_LOAD = 6'(2 * DIM);      // one extra step drains the RAM read
  localparam logic [5:0] LAST_ROW  = 6'(2 * DIM - 1);
  localparam int         WCW       = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(RUN_CYCLES - 1);

  state_e            state_q, state_d;
  logic [5:0]        step_q, step_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic [SRC_AW-1:0] src_base_q, dst_base_q;
  logic              armed_q;
  logic              accept;
  logic              skip_clr;
  logic [5:0]        load_row;

  // A start in the very cycle reset is released is dropped: armed_q is still 0 then.
  assign accept   = (state_q == ST_IDLE) && start && armed_q;
  assign load_row = step_q - 6'd1;

`ifdef TPU_SEQ_ACCUM_EN
  logic skip_clr_q;

  // Latch the accumulate request together with the accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      skip_clr_q <= 1'b0;
    else if (accept) skip_clr_q <= accum;
  end

  assign skip_clr = skip_clr_q;
`else
  logic unused_accum;
  assign unused_accum = accum;
  assign skip_clr     = 1'b0;
`endif

  // Next-state logic for the FSM, the shared step counter and the WAIT counter.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
    state_d = state_q;
    step_d  = step_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOAD_AB;
          step_d  = 6'd0;
        end
      end
      ST_LOAD_AB: begin
        if (step_q == LAST_LOAD) begin
          step_d  = 6'd0;
          state_d = skip_clr ? ST_TRIG : ST_CLR_C;
        end else begin
          step_d = step_q + 6'd1;
        end
      end
      ST_CLR_C: begin
        if (step_q == LAST_ROW) begin
          step_d  = 6'd0;
          state_d = ST_TRIG;
        end else begin
          step_d = step_q + 6'd1;
        end
      end
      ST_TRIG: begin
        state_d = ST_WAIT;
        wait_d  = WAIT_LOAD;
      end
      ST_WAIT: begin
        if (wait_q == '0) state_d = ST_READ_C;
        else              wait_d  = wait_q - 1'b1;
      end
      ST_READ_C: begin
        if (step_q == LAST_ROW) begin
          step_d  = 6'd0;
          state_d = ST_DONE;
        end else begin
          step_d = step_q + 6'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and step; the bus is parked whenever it is not in use.
  always_comb begin
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    src_rd        = 1'b0;
    src_addr      = '0;
    dst_we        = 1'b0;
    dst_addr      = '0;
    dst_wdata     = '0;
    tpu.tpu_r_w   = 1'b0;
    tpu.tpu_addr  = ADDRW'(PARK_ADDR);
    tpu.tpu_wdata = '0;
    case (state_q)
      ST_LOAD_AB: begin
        if (step_q != LAST_LOAD) begin
          src_rd   = 1'b1;
          src_addr = src_base_q + SRC_AW'(step_q);
        end
        // RAM data returns one cycle after its read, so writes trail reads by one step.
        if (step_q != 6'd0) begin
          tpu.tpu_r_w   = 1'b1;
          tpu.tpu_wdata = src_rdata;
          tpu.tpu_addr  = (load_row < ROWS_A) ? ADDRW'(row_addr(A_BASE, load_row))
                                              : ADDRW'(row_addr(B_BASE, load_row - ROWS_A));
        end
      end
      ST_CLR_C: begin
        tpu.tpu_r_w  = 1'b1;
        tpu.tpu_addr = ADDRW'(row_addr(C_BASE, step_q));
      end
      ST_TRIG: tpu.tpu_addr = ADDRW'(MM_TRIG);
      ST_READ_C: begin
        tpu.tpu_addr = ADDRW'(row_addr(C_BASE, step_q));
        dst_we       = 1'b1;
        dst_addr     = dst_base_q + SRC_AW'(step_q);
        dst_wdata    = tpu.tpu_rdata;
      end
      default: ;
    endcase
  end

  // State, counters and the bases captured at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= 6'd0;
      wait_q     <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, matching the hardware.
      state_q <= state_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      armed_q <= 1'b1;
      if (accept) begin
        src_base_q <= src_base;
        dst_base_q <= dst_base;
      end
    end
  end

endmodule

// File: tb/tb_tpu_mm_sequencer.sv
// tb_tpu_mm_sequencer: directed + randomized bench with a behavioural TPU and RAMs.
module tb_tpu_mm_sequencer;
  import tpu_seq_pkg::*;

  localparam int DATAW      = 64;
  localparam int ADDRW      = 16;
  localparam int DIM        = 8;
  localparam int SRC_AW     = 10;
  localparam int RUN_CYCLES = 32;
  localparam int MAXC       = 200;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              accum = 1'b0;
  logic [SRC_AW-1:0] src_base = '0;
  logic [SRC_AW-1:0] dst_base = '0;
  logic              busy, done, src_rd, dst_we;
  logic [SRC_AW-1:0] src_addr, dst_addr;
  logic [DATAW-1:0]  src_rdata = '0;
  logic [DATAW-1:0]  dst_wdata;

  tpu_mm_sequencer_if #(.DATAW(DATAW), .ADDRW(ADDRW)) tpu_bus ();

  tpu_mm_sequencer #(
    .DATAW(DATAW), .ADDRW(ADDRW), .DIM(DIM), .SRC_AW(SRC_AW), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
    .accum(accum), .busy(busy), .done(done), .src_rd(src_rd), .src_addr(src_addr),
    .src_rdata(src_rdata), .dst_we(dst_we), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
    .tpu(tpu_bus)
  );

  always #5 clk = ~clk;

  // Source RAM with one cycle of read latency.
  logic [63:0] src_mem [1024];
  always @(posedge clk) if (src_rd) src_rdata <= src_mem[src_addr];

  // Behavioural TPU: A/B/C registers, trigger does C += A*B on signed bytes.
  logic [63:0] t_a [8];
  logic [63:0] t_b [8];
  logic [63:0] t_c [16];
  logic [15:0] fa;
  int          fs;
  always @(posedge clk) begin
    fa = tpu_bus.tpu_addr;
    if (tpu_bus.tpu_r_w) begin
      if (fa >= 16'h0100 && fa < 16'h0140)      t_a[fa[5:3]] <= tpu_bus.tpu_wdata;
      else if (fa >= 16'h0200 && fa < 16'h0240) t_b[fa[5:3]] <= tpu_bus.tpu_wdata;
      else if (fa >= 16'h0300 && fa < 16'h0380) t_c[fa[6:3]] <= tpu_bus.tpu_wdata;
    end else if (fa == 16'h0400) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          fs = 0;
          for (int i = 0; i < 8; i++)
            fs += int'($signed(t_a[r][8*i +: 8])) * int'($signed(t_b[i][8*c +: 8]));
          t_c[2*r + c/4][16*(c%4) +: 16] <= t_c[2*r + c/4][16*(c%4) +: 16] + 16'(fs);
        end
    end
  end

  always_comb begin
    tpu_bus.tpu_rdata = 64'h0;
    if (tpu_bus.tpu_addr >= 16'h0300 && tpu_bus.tpu_addr < 16'h0380)
      tpu_bus.tpu_rdata = t_c[tpu_bus.tpu_addr[6:3]];
  end

  // Reference matrices and the expected C half-row contents.
  int ref_a [8][8];
  int ref_b [8][8];

  function automatic logic [63:0] ref_half(input int j, input int mult);
    logic [63:0] w = '0;
    for (int e = 0; e < 4; e++) begin
      int s = 0;
      for (int i = 0; i < 8; i++) s += ref_a[j/2][i] * ref_b[i][4*(j%2) + e];
      w[16*e +: 16] = 16'(s * mult);
    end
    return w;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s ctrl", tag), {busy, done, src_rd, dst_we, tpu_bus.tpu_r_w}, '0);
    check($sformatf("%s addr", tag), {tpu_bus.tpu_addr, src_addr, dst_addr}, '0);
    check($sformatf("%s data", tag), {tpu_bus.tpu_wdata, dst_wdata}, '0);
  endtask

  // Fill reference matrices (identity/ramp or random) and place rows in source RAM.
  task automatic load_mats(input logic [9:0] sb, input bit ident);
    logic [7:0]  bt;
    logic [63:0] w;
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 8; i++) begin
        if (ident) begin
          ref_a[r][i] = (r == i) ? 1 : 0;
          ref_b[r][i] = i + 1;
        end else begin
          bt = 8'($urandom);
          ref_a[r][i] = int'($signed(bt));
          bt = 8'($urandom);
          ref_b[r][i] = int'($signed(bt));
        end
      end
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 8; i++) w[8*i +: 8] = (k < 8) ? 8'(ref_a[k][i]) : 8'(ref_b[k-8][i]);
      src_mem[10'(sb + k)] = w;
    end
  endtask

  // Per-cycle trace of one run, indexed by cycle number after the start sample.
  logic [15:0] r_addr [MAXC];
  logic        r_rw   [MAXC];
  logic [63:0] r_wd   [MAXC];
  logic        r_srd  [MAXC];
  logic [9:0]  r_sa   [MAXC];
  logic        r_dwe  [MAXC];
  logic [9:0]  r_da   [MAXC];
  logic [63:0] r_dd   [MAXC];
  logic        r_busy [MAXC];

  task automatic run_op(input string tag, input logic [9:0] sb, input logic [9:0] db,
                        input bit acc, input bit pulse_mid, output int done_cyc);
    int n_done = 0;
    done_cyc = -1;
    @(negedge clk);
    src_base = sb; dst_base = db; accum = acc; start = 1'b1;
    for (int c = 1; c < MAXC; c++) begin
      @(negedge clk);
      r_addr[c] = tpu_bus.tpu_addr;  r_rw[c] = tpu_bus.tpu_r_w;  r_wd[c] = tpu_bus.tpu_wdata;
      r_srd[c]  = src_rd;  r_sa[c] = src_addr;  r_dwe[c] = dst_we;  r_da[c] = dst_addr;
      r_dd[c]   = dst_wdata;  r_busy[c] = busy;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      start = pulse_mid && (c == 10 || c == 50);
      if (done_cyc > 0 && c >= done_cyc + 5) break;
    end
    start = 1'b0;
    accum = 1'b0;
    check($sformatf("%s done_count", tag), n_done, 1);
  endtask

  // Compare a recorded run against the expected bus/RAM transaction lists.
  task automatic check_run(input string tag, input logic [9:0] sb, input logic [9:0] db,
                           input bit skip, input int mult, input int dc);
    int          exp_done = skip ? 67 : 83;
    int          trig_c   = skip ? 18 : 34;
    int          last     = (dc > 0) ? dc - 1 : MAXC - 1;
    int          wr_cyc0  = -1;
    logic [79:0] wr_q[$], wr_exp[$];
    logic [15:0] rd_q[$], rd_exp[$];
    int          rd_cyc[$], sa_cyc[$];
    logic [9:0]  sa_q[$], da_q[$];
    logic [63:0] dd_q[$];
    logic [79:0] w80;
    logic [15:0] v16;
    logic [9:0]  v10;
    logic [63:0] v64;

    check($sformatf("%s done_cycle", tag), dc, exp_done);
    for (int c = 1; c <= last; c++) begin
      if (r_srd[c]) begin sa_q.push_back(r_sa[c]); sa_cyc.push_back(c); end
      if (r_rw[c]) begin
        wr_q.push_back({r_addr[c], r_wd[c]});
        if (wr_cyc0 < 0) wr_cyc0 = c;
      end else if (r_addr[c] != 16'h0000) begin
        rd_q.push_back(r_addr[c]); rd_cyc.push_back(c);
      end
      if (r_dwe[c]) begin da_q.push_back(r_da[c]); dd_q.push_back(r_dd[c]); end
    end

    for (int k = 0; k < 16; k++)
      wr_exp.push_back({(k < 8) ? 16'h0100 + 16'(8*k) : 16'h0200 + 16'(8*(k-8)), src_mem[10'(sb + k)]});
    if (!skip) for (int j = 0; j < 16; j++) wr_exp.push_back({16'h0300 + 16'(8*j), 64'h0});
    rd_exp.push_back(16'h0400);
    for (int j = 0; j < 16; j++) rd_exp.push_back(16'h0300 + 16'(8*j));

    check($sformatf("%s src_read_count", tag), sa_q.size(), 16);
    check($sformatf("%s src_first_cycle", tag), (sa_cyc.size() > 0) ? sa_cyc[0] : -1, 1);
    for (int k = 0; k < 16; k++) begin
      v10 = (k < sa_q.size()) ? sa_q[k] : 10'bx;
      check($sformatf("%s src_addr%0d", tag, k), v10, 10'(sb + k));
    end

    check($sformatf("%s wr_count", tag), wr_q.size(), wr_exp.size());
    check($sformatf("%s wr_first_cycle", tag), wr_cyc0, 2);
    for (int k = 0; k < wr_exp.size(); k++) begin
      w80 = (k < wr_q.size()) ? wr_q[k] : 80'bx;
      check($sformatf("%s wr%0d", tag, k), w80, wr_exp[k]);
    end

    check($sformatf("%s rd_count", tag), rd_q.size(), rd_exp.size());
    check($sformatf("%s trig_cycle", tag), (rd_cyc.size() > 0) ? rd_cyc[0] : -1, trig_c);
    check($sformatf("%s first_c_read", tag), (rd_cyc.size() > 1) ? rd_cyc[1] : -1,
          trig_c + RUN_CYCLES + 1);
    for (int k = 0; k < rd_exp.size(); k++) begin
      v16 = (k < rd_q.size()) ? rd_q[k] : 16'bx;
      check($sformatf("%s rd%0d", tag, k), v16, rd_exp[k]);
    end

    check($sformatf("%s dst_count", tag), da_q.size(), 16);
    for (int j = 0; j < 16; j++) begin
      v10 = (j < da_q.size()) ? da_q[j] : 10'bx;
      v64 = (j < dd_q.size()) ? dd_q[j] : 64'bx;
      check($sformatf("%s dst_addr%0d", tag, j), v10, 10'(db + j));
      check($sformatf("%s dst_data%0d", tag, j), v64, ref_half(j, mult));
    end

    if (dc > 0 && dc + 1 < MAXC) begin
      check($sformatf("%s busy_at_done", tag), r_busy[dc], 1'b1);
      check($sformatf("%s idle_after_done", tag), r_busy[dc + 1], 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          dc;
    logic [9:0]  sb, db;
    bit          skip_exp;
    int          mult_exp;

    // Reset: all outputs low while rst_n is asserted.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");

    // start coinciding with reset release must be dropped.
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_at_release busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("start_at_release still_idle", busy, 1'b0);

    // Identity A, ramp B: C reproduces B sign-extended.
    load_mats(10'h010, 1'b1);
    run_op("ident", 10'h010, 10'h100, 1'b0, 1'b0, dc);
    check_run("ident", 10'h010, 10'h100, 1'b0, 1, dc);

    // Start pulses during a run are ignored.
    load_mats(10'h040, 1'b0);
    run_op("pulse", 10'h040, 10'h200, 1'b0, 1'b1, dc);
    check_run("pulse", 10'h040, 10'h200, 1'b0, 1, dc);

    // Address wrap on both RAMs.
    load_mats(10'h3F8, 1'b0);
    run_op("wrap", 10'h3F8, 10'h3F8, 1'b0, 1'b0, dc);
    check_run("wrap", 10'h3F8, 10'h3F8, 1'b0, 1, dc);

    // Two runs on identical data; the second requests accumulation.
    load_mats(10'h080, 1'b0);
    run_op("acc_first", 10'h080, 10'h280, 1'b0, 1'b0, dc);
    check_run("acc_first", 10'h080, 10'h280, 1'b0, 1, dc);
`ifdef TPU_SEQ_ACCUM_EN
    skip_exp = 1'b1;
    mult_exp = 2;
`else
    skip_exp = 1'b0;
    mult_exp = 1;
`endif
    run_op("acc_second", 10'h080, 10'h2A0, 1'b1, 1'b0, dc);
    check_run("acc_second", 10'h080, 10'h2A0, skip_exp, mult_exp, dc);

    // Reset in the middle of a run, then a clean run afterwards.
    load_mats(10'h0C0, 1'b0);
    @(negedge clk);
    src_base = 10'h0C0; dst_base = 10'h300; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midreset busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_op("after_reset", 10'h0C0, 10'h300, 1'b0, 1'b0, dc);
    check_run("after_reset", 10'h0C0, 10'h300, 1'b0, 1, dc);

    // Random bases and data.
    for (int t = 0; t < 3; t++) begin
      sb = 10'($urandom_range(0, 1023));
      db = 10'($urandom_range(0, 1023));
      load_mats(sb, 1'b0);
      run_op($sformatf("rand%0d", t), sb, db, 1'b0, 1'b0, dc);
      check_run($sformatf("rand%0d", t), sb, db, 1'b0, 1, dc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
